// File: rtl/gpio_pad_if.sv
// Pin-side bundle between SoC GPIO logic and the pad controller.
// master = SoC/pin logic, slave = gpio_pad_ctrl.
interface gpio_pad_if #(
  parameter int NUM_PINS = 24,
  parameter int FILT_W   = 4
);
  logic [NUM_PINS-1:0] out_i;
  logic [NUM_PINS-1:0] oe_i;
  logic [NUM_PINS-1:0] od_i;
  logic [NUM_PINS-1:0] filt_en_i;
  logic [FILT_W-1:0]   filt_len_i;
  logic [NUM_PINS-1:0] irq_rise_en_i;
  logic [NUM_PINS-1:0] irq_fall_en_i;
  logic [NUM_PINS-1:0] irq_clr_i;
  logic [NUM_PINS-1:0] pad_i;
  logic [NUM_PINS-1:0] pad_o;
  logic [NUM_PINS-1:0] pad_oe;
  logic [NUM_PINS-1:0] in_o;
  logic [NUM_PINS-1:0] irq_status_o;
  logic                irq_o;

  modport master (
    output out_i, oe_i, od_i, filt_en_i, filt_len_i,
    output irq_rise_en_i, irq_fall_en_i, irq_clr_i, pad_i,
    input  pad_o, pad_oe, in_o, irq_status_o, irq_o
  );

  modport slave (
    input  out_i, oe_i, od_i, filt_en_i, filt_len_i,
    input  irq_rise_en_i, irq_fall_en_i, irq_clr_i, pad_i,
    output pad_o, pad_oe, in_o, irq_status_o, irq_o
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// N-pin pad controller: registered drive, input sync,
// glitch filter, edge detect with sticky W1C status.
module gpio_pad_ctrl #(
  parameter int NUM_PINS    = 24,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input logic       clk,
  input logic       rst_n,
  gpio_pad_if.slave bus
);

  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_N = PW'(SYNC_STAGES + 1);
  localparam logic [FILT_W-1:0] CNT_MAX = '1;

  logic [NUM_PINS-1:0] r_sync [SYNC_STAGES];
  logic [FILT_W-1:0]   r_cnt [NUM_PINS];
  logic [NUM_PINS-1:0] r_in;
  logic [NUM_PINS-1:0] r_in_q;
  logic [NUM_PINS-1:0] r_stat;
  logic [NUM_PINS-1:0] r_pad_o;
  logic [NUM_PINS-1:0] r_pad_oe;
  logic [PW-1:0]       r_prime;

  logic                w_prime;
  logic [NUM_PINS-1:0] w_s;
  logic [NUM_PINS-1:0] w_set;
  logic [NUM_PINS-1:0] w_hit;
  logic [FILT_W-1:0]   w_len;
  logic [FILT_W-1:0]   w_lm1;

  assign w_prime = (r_prime != PRIME_N);
  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_len   = (bus.filt_len_i == '0) ?
                   FILT_W'(1) : bus.filt_len_i;
  assign w_lm1   = w_len - FILT_W'(1);

  // Edges are ignored until the sync chain holds real pad data
  assign w_set = ((r_in & ~r_in_q & bus.irq_rise_en_i) |
                  (~r_in & r_in_q & bus.irq_fall_en_i)) &
                 {NUM_PINS{~w_prime}};

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_PINS; i++)
      w_hit[i] = ~bus.filt_en_i[i] | (r_cnt[i] >= w_lm1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        r_sync[k] <= '0;
      for (int i = 0; i < NUM_PINS; i++)
        r_cnt[i] <= '0;
      r_in     <= '0;
      r_in_q   <= '0;
      r_stat   <= '0;
      r_pad_o  <= '0;
      r_pad_oe <= '0;
      r_prime  <= '0;
    end else begin
      r_sync[0] <= bus.pad_i;
      for (int k = 1; k < SYNC_STAGES; k++)
        r_sync[k] <= r_sync[k-1];
      if (w_prime)
        r_prime <= r_prime + PW'(1);
      // in_q tracks the bypass value so priming ends with no edge
      r_in_q   <= w_prime ? w_s : r_in;
      r_stat   <= (r_stat & ~bus.irq_clr_i) | w_set;
      r_pad_oe <= bus.oe_i & ~(bus.od_i & bus.out_i);
      r_pad_o  <= bus.out_i & ~bus.od_i;
      for (int i = 0; i < NUM_PINS; i++) begin
        if (w_prime || (w_s[i] == r_in[i]) || w_hit[i]) begin
          r_in[i]  <= w_s[i];
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != CNT_MAX) begin
          r_cnt[i] <= r_cnt[i] + FILT_W'(1);
        end
      end
    end
  end

  assign bus.pad_o        = r_pad_o;
  assign bus.pad_oe       = r_pad_oe;
  assign bus.in_o         = r_in;
  assign bus.irq_status_o = r_stat;
  assign bus.irq_o        = |r_stat;

endmodule
